// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: FSM state encoding and default widths.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } ctrl_state_t;

  localparam int unsigned REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-stall cycles and raises a sticky timeout at MAX_WAIT.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic stall,
  output logic timeout
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  // Count saturates at MAX_WAIT so very long waits cannot wrap.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (stall) begin
      if (wait_cnt != CW'(MAX_WAIT))
        wait_cnt <= wait_cnt + CW'(1);
      if (wait_cnt == CW'(MAX_WAIT - 1))
        timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use, taken branch, memory wait.
// Optional performance counters (stall_cnt, flush_cnt) enabled by defining HAZARD_PERF_EN.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned MAX_WAIT   = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  ifid_flush,
  output logic                  idex_we,
  output logic                  idex_flush,
  output logic                  exmem_we,
  output logic                  exmem_flush,
  output logic                  memwb_we,
  output logic                  memwb_flush,
  output logic                  fsm_state,
  output logic                  mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  ctrl_state_t state, state_nxt;
  logic        mem_stall;
  logic        load_use;

  assign mem_stall = mem_req && !mem_ready;
  assign load_use  = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (mem_stall) state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!mem_stall) state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  // Memory stall outranks branch so a taken branch waits in EX until the pipe advances.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_flush  = 1'b0;
    exmem_we    = 1'b1;
    exmem_flush = 1'b0;
    memwb_we    = 1'b1;
    memwb_flush = 1'b0;
    if (Rst) begin
      pc_we       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign fsm_state = state;

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_mem_wait_timer (
    .Clk    (Clk),
    .Rst    (Rst),
    .stall  (mem_stall),
    .timeout(mem_timeout)
  );

`ifdef HAZARD_PERF_EN
  logic branch_flush;
  assign branch_flush = !mem_stall && ex_branch_taken;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected responses, a negedge monitor checks.
module tb_hazard_ctrl;

  localparam logic [8:0] C_NORM  = 9'b1_10_10_10_10;
  localparam logic [8:0] C_LU    = 9'b0_00_11_10_10;
  localparam logic [8:0] C_BR    = 9'b1_11_11_10_10;
  localparam logic [8:0] C_STALL = 9'b0_00_00_00_11;
  localparam logic [8:0] C_RST   = 9'b0_11_11_11_11;

  typedef struct {
    logic [8:0] ctrl;
    logic       fsm;
    logic       tmo;
    string      name;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;
  logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
  logic       exmem_we, exmem_flush, memwb_we, memwb_flush;
  logic       fsm_state, mem_timeout;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  hazard_ctrl #(
    .REG_ADDR_W(5),
    .MAX_WAIT  (16),
    .CNT_W     (32)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_we          (pc_we),
    .ifid_we        (ifid_we),
    .ifid_flush     (ifid_flush),
    .idex_we        (idex_we),
    .idex_flush     (idex_flush),
    .exmem_we       (exmem_we),
    .exmem_flush    (exmem_flush),
    .memwb_we       (memwb_we),
    .memwb_flush    (memwb_flush),
    .fsm_state      (fsm_state),
    .mem_timeout    (mem_timeout)
  );

  always #5 Clk = ~Clk;

  // One cycle of stimulus: drive after the edge, queue what the monitor must see this cycle.
  task automatic step(input logic rst, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic ld, input logic br, input logic req, input logic rdy,
                      input logic [8:0] ectrl, input logic efsm, input logic etmo,
                      input string nm);
    exp_t e;
    @(posedge Clk);
    #1;
    Rst = rst; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = ld; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
    e.ctrl = ectrl; e.fsm = efsm; e.tmo = etmo; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [8:0] ectrl, input logic efsm, input logic etmo, input string nm);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ectrl, efsm, etmo, nm);
  endtask

  task automatic memstall(input logic br, input logic efsm, input logic etmo, input string nm);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, br, 1'b1, 1'b0, C_STALL, efsm, etmo, nm);
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [8:0] got;
      e = exp_q.pop_front();
      got = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
             exmem_we, exmem_flush, memwb_we, memwb_flush};
      checks++;
      if (got !== e.ctrl) begin
        errors++;
        $display("FAIL %s ctrl got=%b want=%b", e.name, got, e.ctrl);
      end
      checks++;
      if (fsm_state !== e.fsm) begin
        errors++;
        $display("FAIL %s fsm_state got=%b want=%b", e.name, fsm_state, e.fsm);
      end
      checks++;
      if (mem_timeout !== e.tmo) begin
        errors++;
        $display("FAIL %s mem_timeout got=%b want=%b", e.name, mem_timeout, e.tmo);
      end
    end
  end

  initial begin
    repeat (2) @(posedge Clk);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST, 1'b0, 1'b0, "reset");
    idle(C_NORM, 1'b0, 1'b0, "idle");

    // Load-use on rs1, then the load has moved on: one bubble only.
    step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, 1'b0, "lu_rs1");
    step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM, 1'b0, 1'b0, "lu_after_ready_same_cycle");
    step(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1'b0, "lu_rd0");
    step(1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, 1'b0, "lu_rs2");
    step(1'b0, 5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1'b0, "lu_rs2_unused");
    step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_BR, 1'b0, 1'b0, "branch_over_lu");

    // Three-cycle memory wait.
    memstall(1'b0, 1'b0, 1'b0, "mw1");
    memstall(1'b0, 1'b1, 1'b0, "mw2");
    memstall(1'b0, 1'b1, 1'b0, "mw3");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM, 1'b1, 1'b0, "mw_ready");
    idle(C_NORM, 1'b0, 1'b0, "mw_done");

    // Branch held in EX across a stall, flushes on the ready cycle.
    memstall(1'b1, 1'b0, 1'b0, "bh1");
    memstall(1'b1, 1'b1, 1'b0, "bh2");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_BR, 1'b1, 1'b0, "bh_ready");
    idle(C_NORM, 1'b0, 1'b0, "bh_done");

    // 15 stalls stay short of the timeout.
    for (int i = 1; i <= 15; i++) memstall(1'b0, (i != 1), 1'b0, "w15");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM, 1'b1, 1'b0, "w15_ready");
    idle(C_NORM, 1'b0, 1'b0, "w15_done");

    // 16 stalls set the sticky timeout; it survives until reset.
    for (int i = 1; i <= 16; i++) memstall(1'b0, (i != 1), 1'b0, "w16");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM, 1'b1, 1'b1, "w16_ready");
    idle(C_NORM, 1'b0, 1'b1, "tmo_sticky");
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST, 1'b0, 1'b1, "tmo_rst");
    idle(C_NORM, 1'b0, 1'b0, "tmo_cleared");

    // Reset asserted in cycle 2 of a wait.
    memstall(1'b0, 1'b0, 1'b0, "rmw1");
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_RST, 1'b1, 1'b0, "rmw_rst");
    idle(C_NORM, 1'b0, 1'b0, "rmw_after");

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge Clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
